// File: rtl/data_bus_responder.sv
`timescale 1ns/1ps
// data_bus_responder
// Responder end of a single-cycle core's data-memory port: word RAM plus a
// 64-byte MMIO window (timer with compare/IRQ, 8-bit GPIO output register).
// Reads are combinational so the core never stalls; writes land on the
// rising clock edge. Build option: define TIMER_EN to include the timer
// (COUNT/CTRL/CMP/STATUS); without it those offsets read 0, ignore writes,
// and Irq is tied low.
module data_bus_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter logic [31:0] MMIO_BASE   = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [7:0]  Gpio,
  output logic        Irq
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  // Word offsets inside the MMIO window
  localparam logic [3:0] OFF_COUNT  = 4'h0;
  localparam logic [3:0] OFF_CTRL   = 4'h1;
  localparam logic [3:0] OFF_CMP    = 4'h2;
  localparam logic [3:0] OFF_STATUS = 4'h3;
  localparam logic [3:0] OFF_GPIO   = 4'h4;

  logic [31:0]   mem_q [DEPTH_WORDS];
  logic          ram_sel;
  logic          mmio_sel;
  logic          mmio_wr;
  logic [AW-1:0] ram_idx;
  logic [3:0]    mmio_off;
  logic [7:0]    gpio_q;
  logic [7:0]    gpio_d;
  logic          unused_addr_bits;

  // Address decode on the word address; byte-lane bits are ignored
  assign ram_sel          = (Address[31:AW+2] == '0);
  assign ram_idx          = Address[AW+1:2];
  assign mmio_sel         = (Address[31:6] == MMIO_BASE[31:6]);
  assign mmio_off         = Address[5:2];
  assign mmio_wr          = MemWrite && mmio_sel && !ram_sel;
  assign unused_addr_bits = ^Address[1:0];

  // RAM write port; a write presented while reset is held is dropped
  always_ff @(posedge clk) begin
    if (reset && MemWrite && ram_sel) begin
      mem_q[ram_idx] <= WriteData;
    end
  end

  // GPIO next state: only the low byte of a store is kept
  always_comb begin
    gpio_d = gpio_q;
    if (mmio_wr && (mmio_off == OFF_GPIO)) begin
      gpio_d = WriteData[7:0];
    end
  end

  // GPIO output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpio_q <= '0;
    end else begin
      gpio_q <= gpio_d;
    end
  end

  assign Gpio = gpio_q;

`ifdef TIMER_EN
  logic [31:0] count_q, count_d;
  logic [31:0] cmp_q, cmp_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic        stat_q, stat_d;
  logic        match;

  // A match only exists while the timer is enabled
  assign match = ctrl_q[0] && (count_q == cmp_q);

  // Timer next state; later assignments win, giving software COUNT writes
  // priority over counting and a match priority over a W1C of STATUS
  always_comb begin
    count_d = count_q;
    ctrl_d  = ctrl_q;
    cmp_d   = cmp_q;
    stat_d  = stat_q;
    if (ctrl_q[0]) begin
      count_d = (match && ctrl_q[1]) ? 32'd0 : count_q + 32'd1;
    end
    if (mmio_wr && (mmio_off == OFF_COUNT)) begin
      count_d = WriteData;
    end
    if (mmio_wr && (mmio_off == OFF_CTRL)) begin
      ctrl_d = WriteData[2:0];
    end
    if (mmio_wr && (mmio_off == OFF_CMP)) begin
      cmp_d = WriteData;
    end
    if (mmio_wr && (mmio_off == OFF_STATUS) && WriteData[0]) begin
      stat_d = 1'b0;
    end
    if (match) begin
      stat_d = 1'b1;
    end
  end

  // Timer registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      ctrl_q  <= '0;
      cmp_q   <= '0;
      stat_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      ctrl_q  <= ctrl_d;
      cmp_q   <= cmp_d;
      stat_q  <= stat_d;
    end
  end

  assign Irq = stat_q & ctrl_q[2];
`else
  assign Irq = 1'b0;
`endif

  // Combinational read mux; returns pre-edge state during a same-cycle write
  always_comb begin
    ReadData = '0;
    if (ram_sel) begin
      ReadData = mem_q[ram_idx];
    end else if (mmio_sel) begin
      case (mmio_off)
`ifdef TIMER_EN
        OFF_COUNT:  ReadData = count_q;
        OFF_CTRL:   ReadData = {29'd0, ctrl_q};
        OFF_CMP:    ReadData = cmp_q;
        OFF_STATUS: ReadData = {31'd0, stat_q};
`endif
        OFF_GPIO:   ReadData = {24'd0, gpio_q};
        default:    ReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_bus_responder.sv
`timescale 1ns/1ps
// Testbench for data_bus_responder: vector table, hand sequences for the
// timer and reset corner cases, and a randomized RAM/GPIO/unmapped stream
// checked against an array model. Follows the TIMER_EN build option.
module tb_data_bus_responder;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [7:0]  Gpio;
  logic        Irq;

  int n_pass;
  int n_total;

  data_bus_responder #(
    .DEPTH_WORDS(64),
    .MMIO_BASE  (32'h0000_1000)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .MemWrite (MemWrite),
    .Address  (Address),
    .WriteData(WriteData),
    .ReadData (ReadData),
    .Gpio     (Gpio),
    .Irq      (Irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic [7:0]  exp_gpio;
  } vec_t;

  vec_t vt[$];

  // Reference model for the randomized phase
  logic [31:0] ram_m [64];
  bit          ram_v [64];
  logic [7:0]  gpio_m;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d);
    MemWrite  = we;
    Address   = a;
    WriteData = d;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    n_pass    = 0;
    n_total   = 0;
    clk       = 1'b0;
    reset     = 1'b1;
    MemWrite  = 1'b0;
    Address   = '0;
    WriteData = '0;

    // ---------------- reset state ----------------
    #3 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gpio", {24'd0, Gpio}, 32'h0);
    chk("rst_irq", {31'd0, Irq}, 32'h0);
    drive(1'b0, 32'h1010, 32'h0);
    chk("rst_gpio_rd", ReadData, 32'h0);
    drive(1'b0, 32'h1000, 32'h0);
    chk("rst_count_rd", ReadData, 32'h0);
    #1 reset = 1'b1;
    step();

    // ---------------- vector table ----------------
    vt.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0,         8'h00});
    vt.push_back('{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF, 8'h00});
    vt.push_back('{1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'hDEAD_BEEF, 8'h00});
    vt.push_back('{1'b1, 32'h0000_0020, 32'h1,         1'b0, 32'h0,         8'h00});
    vt.push_back('{1'b1, 32'h0000_0020, 32'h2,         1'b1, 32'h1,         8'h00});
    vt.push_back('{1'b0, 32'h0000_0020, 32'h0,         1'b1, 32'h2,         8'h00});
    vt.push_back('{1'b1, 32'h0000_0000, 32'h1234_5678, 1'b0, 32'h0,         8'h00});
    vt.push_back('{1'b1, 32'h0000_0800, 32'hFFFF_FFFF, 1'b1, 32'h0,         8'h00});
    vt.push_back('{1'b0, 32'h0000_0800, 32'h0,         1'b1, 32'h0,         8'h00});
    vt.push_back('{1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'h1234_5678, 8'h00});
    vt.push_back('{1'b1, 32'h8000_0010, 32'h0BAD_0BAD, 1'b0, 32'h0,         8'h00});
    vt.push_back('{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF, 8'h00});
    vt.push_back('{1'b1, 32'h0000_1010, 32'h0000_01A5, 1'b1, 32'h0,         8'h00});
    vt.push_back('{1'b0, 32'h0000_1010, 32'h0,         1'b1, 32'h0000_00A5, 8'hA5});
    vt.push_back('{1'b1, 32'h0000_1050, 32'h0000_0055, 1'b1, 32'h0,         8'hA5});
    vt.push_back('{1'b0, 32'h0000_1010, 32'h0,         1'b1, 32'h0000_00A5, 8'hA5});
    vt.push_back('{1'b0, 32'h0000_1014, 32'h0,         1'b1, 32'h0,         8'hA5});
    vt.push_back('{1'b1, 32'h0000_00FC, 32'hCAFE_F00D, 1'b0, 32'h0,         8'hA5});
    vt.push_back('{1'b0, 32'h0000_00FC, 32'h0,         1'b1, 32'hCAFE_F00D, 8'hA5});
    vt.push_back('{1'b0, 32'h0000_0100, 32'h0,         1'b1, 32'h0,         8'hA5});

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].we, vt[i].addr, vt[i].wdata);
      if (vt[i].chk_rd) chk($sformatf("vec%0d_rd", i), ReadData, vt[i].exp_rd);
      chk($sformatf("vec%0d_gpio", i), {24'd0, Gpio}, {24'd0, vt[i].exp_gpio});
      chk($sformatf("vec%0d_irq", i), {31'd0, Irq}, 32'h0);
      step();
    end

`ifdef TIMER_EN
    // ---------------- timer: compare, clear-on-match, IRQ ----------------
    drive(1'b1, 32'h1008, 32'd5);
    step();
    drive(1'b1, 32'h1004, 32'd7);
    step();
    drive(1'b0, 32'h1000, 32'h0);
    n = 0;
    while (!Irq && n < 20) begin
      step();
      n++;
    end
    chk("tmr_irq_latency", 32'(n), 32'd6);
    chk("tmr_irq_set", {31'd0, Irq}, 32'h1);
    chk("tmr_count_cleared", ReadData, 32'h0);

    // W1C clears flag, Irq drops after that edge
    drive(1'b1, 32'h100C, 32'h1);
    step();
    drive(1'b0, 32'h100C, 32'h0);
    chk("tmr_w1c_irq", {31'd0, Irq}, 32'h0);
    chk("tmr_w1c_status", ReadData, 32'h0);

    // W1C on the match edge: flag stays set
    drive(1'b1, 32'h1000, 32'd4);
    step();
    drive(1'b0, 32'h1000, 32'h0);
    chk("tmr_count_wr4", ReadData, 32'd4);
    step();
    chk("tmr_count_5", ReadData, 32'd5);
    drive(1'b1, 32'h100C, 32'h1);
    step();
    drive(1'b0, 32'h100C, 32'h0);
    chk("tmr_w1c_match_status", ReadData, 32'h1);
    chk("tmr_w1c_match_irq", {31'd0, Irq}, 32'h1);
    drive(1'b0, 32'h1000, 32'h0);
    chk("tmr_w1c_match_count", ReadData, 32'h0);

    // Wrap with no flag; enable takes effect from the following edge
    drive(1'b1, 32'h1004, 32'h0);
    step();
    drive(1'b1, 32'h100C, 32'h1);
    step();
    chk("tmr_disabled_irq", {31'd0, Irq}, 32'h0);
    drive(1'b1, 32'h1008, 32'h10);
    step();
    drive(1'b0, 32'h1008, 32'h0);
    chk("tmr_cmp_rd", ReadData, 32'h10);
    drive(1'b1, 32'h1000, 32'hFFFF_FFFF);
    step();
    drive(1'b0, 32'h1000, 32'h0);
    chk("tmr_count_max", ReadData, 32'hFFFF_FFFF);
    drive(1'b1, 32'h1004, 32'h1);
    step();
    drive(1'b0, 32'h1000, 32'h0);
    chk("tmr_enable_edge_hold", ReadData, 32'hFFFF_FFFF);
    step();
    chk("tmr_wrap", ReadData, 32'h0);
    drive(1'b0, 32'h100C, 32'h0);
    chk("tmr_wrap_noflag", ReadData, 32'h0);

    // Software COUNT write beats increment
    drive(1'b1, 32'h1000, 32'd7);
    step();
    drive(1'b0, 32'h1000, 32'h0);
    chk("tmr_count_wr7", ReadData, 32'd7);
    step();
    chk("tmr_count_8", ReadData, 32'd8);

    // CTRL keeps only three bits
    drive(1'b1, 32'h1004, 32'hFFFF_FFFE);
    step();
    drive(1'b0, 32'h1004, 32'h0);
    chk("tmr_ctrl_rd", ReadData, 32'd6);

    // Disabled: count holds, no match even when COUNT==CMP
    drive(1'b1, 32'h1000, 32'd3);
    step();
    drive(1'b1, 32'h1008, 32'd3);
    step();
    drive(1'b0, 32'h1000, 32'h0);
    step();
    step();
    chk("tmr_hold_count", ReadData, 32'd3);
    drive(1'b0, 32'h100C, 32'h0);
    chk("tmr_hold_noflag", ReadData, 32'h0);
    chk("tmr_hold_irq", {31'd0, Irq}, 32'h0);

    // Arm a match so Irq is high going into the reset test
    drive(1'b1, 32'h1008, 32'd2);
    step();
    drive(1'b1, 32'h1000, 32'd0);
    step();
    drive(1'b1, 32'h1004, 32'd7);
    step();
    drive(1'b0, 32'h1000, 32'h0);
    repeat (3) step();
    chk("tmr_prerst_irq", {31'd0, Irq}, 32'h1);
`else
    // ---------------- no timer: offsets read 0, Irq low ----------------
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h1000 + 32'(i * 4), 32'hFFFF_FFFF);
      step();
      drive(1'b0, 32'h1000 + 32'(i * 4), 32'h0);
      chk($sformatf("notmr_off%0d_rd", i), ReadData, 32'h0);
      chk($sformatf("notmr_off%0d_irq", i), {31'd0, Irq}, 32'h0);
    end
`endif

    // ---------------- async reset mid-operation ----------------
    drive(1'b1, 32'h30, 32'h1111_1111);
    step();
    drive(1'b1, 32'h1010, 32'h5A);
    step();
    drive(1'b0, 32'h1010, 32'h0);
    chk("prerst_gpio", {24'd0, Gpio}, 32'h5A);
    #2 reset = 1'b0;
    #1;
    chk("arst_gpio", {24'd0, Gpio}, 32'h0);
    chk("arst_irq", {31'd0, Irq}, 32'h0);
    chk("arst_gpio_rd", ReadData, 32'h0);
    Address = 32'h1000;
    #1;
    chk("arst_count_rd", ReadData, 32'h0);
    Address = 32'h1004;
    #1;
    chk("arst_ctrl_rd", ReadData, 32'h0);
    MemWrite  = 1'b1;
    Address   = 32'h30;
    WriteData = 32'h2222_2222;
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    #2 reset = 1'b1;
    step();
    drive(1'b0, 32'h30, 32'h0);
    chk("arst_write_aborted", ReadData, 32'h1111_1111);
    chk("postrst_gpio", {24'd0, Gpio}, 32'h0);
    chk("postrst_irq", {31'd0, Irq}, 32'h0);

    // ---------------- randomized stream vs model ----------------
    for (int i = 0; i < 64; i++) ram_v[i] = 1'b0;
    gpio_m = 8'h00;
    for (int k = 0; k < 300; k++) begin
      int unsigned sel;
      int unsigned idx;
      logic        we;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] exp;
      logic        known;
      sel   = $urandom_range(0, 9);
      we    = 1'($urandom_range(0, 1));
      d     = $urandom;
      idx   = 0;
      known = 1'b1;
      exp   = 32'h0;
      if (sel < 6) begin
        idx   = $urandom_range(0, 63);
        a     = 32'(idx * 4 + $urandom_range(0, 3));
        exp   = ram_m[idx];
        known = ram_v[idx];
      end else if (sel < 8) begin
        a   = 32'h1010 + 32'($urandom_range(0, 3));
        exp = {24'd0, gpio_m};
      end else begin
        case ($urandom_range(0, 3))
          0: a = 32'h100 + 32'($urandom_range(0, 32'hEFF));
          1: a = 32'h1014 + 32'($urandom_range(0, 43));
          2: a = 32'h8000_0000 | $urandom;
`ifdef TIMER_EN
          default: a = 32'h1040 + 32'($urandom_range(0, 32'hFF));
`else
          default: a = 32'h1000 + 32'($urandom_range(0, 15));
`endif
        endcase
      end
      drive(we, a, d);
      if (known) chk($sformatf("rand%0d_rd@%h", k, a), ReadData, exp);
      chk($sformatf("rand%0d_gpio", k), {24'd0, Gpio}, {24'd0, gpio_m});
      if (we) begin
        if (sel < 6) begin
          ram_m[idx] = d;
          ram_v[idx] = 1'b1;
        end else if (sel < 8) begin
          gpio_m = d[7:0];
        end
      end
      step();
    end
    MemWrite = 1'b0;
    chk("final_irq", {31'd0, Irq}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
